// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths and loader FSM state encoding.
//            Optional CHK state exists only with IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;
    localparam int ADDR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CHK   = 3'd7
`endif
    } loader_state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input loader_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_rest_state(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_pair_assembler.sv
// ============================================================================
// Module   : byte_pair_assembler
// Purpose  : Pairs hi/lo stream bytes into a 16-bit word with a one-cycle
//            write strobe; keeps the payload XOR under IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_pair_assembler
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic               wr_en,
    output logic [INSTR_W-1:0] wr_data
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [BYTE_W-1:0]  csum
`endif
);

    logic [BYTE_W-1:0]  r_hi;
    logic               r_wr_en;
    logic [INSTR_W-1:0] r_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= lo_we;
            if (clr) begin
                r_hi <= '0;
            end else if (hi_we) begin
                r_hi <= byte_in;
            end
            if (lo_we) begin
                r_wr_data <= {r_hi, byte_in};
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_data = r_wr_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;

    // Length bytes never reach this block, so only payload is folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (clr) begin
            r_csum <= '0;
        end else if (hi_we || lo_we) begin
            r_csum <= r_csum ^ byte_in;
        end
    end

    assign csum = r_csum;
`endif

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a length-prefixed big-endian 16-bit program from a byte
//            stream into the instruction store, holding the CPU meanwhile.
//            Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import cpu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    input  logic               start,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W-1:0]  words_loaded
);

    localparam logic [ADDR_W-1:0] c_max_words = ADDR_W'(MEM_BYTES / 2);
    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;
    logic [BYTE_W-1:0]  r_len_hi;
    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_words_loaded;
    logic [ADDR_W-1:0]  r_wr_addr;

    logic               w_xfer;
    logic               w_start_ok;
    logic               w_hi_we;
    logic               w_lo_we;
    logic               w_last;
    logic [ADDR_W-1:0]  w_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  w_csum;
`endif

    assign in_ready   = is_rx_state(r_state);
    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && is_rest_state(r_state);
    assign w_hi_we    = w_xfer && (r_state == ST_DATA_HI);
    assign w_lo_we    = w_xfer && (r_state == ST_DATA_LO);
    assign w_len      = {r_len_hi, in_data};
    assign w_last     = (r_words_loaded + 16'd1) == r_len;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_start_ok) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_xfer) w_state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state_nxt = ST_CHK;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else if (w_len > c_max_words) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_state_nxt = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (w_xfer) w_state_nxt = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_nxt = w_last ? ST_CHK : ST_DATA_HI;
`else
                    w_state_nxt = w_last ? ST_DONE : ST_DATA_HI;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_xfer) w_state_nxt = (in_data == w_csum) ? ST_DONE : ST_ERROR;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_len_hi       <= '0;
            r_len          <= '0;
            r_words_loaded <= '0;
            r_wr_addr      <= c_base;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_words_loaded <= '0;
                r_wr_addr      <= c_base;
            end
            if (w_xfer && (r_state == ST_LEN_HI)) r_len_hi <= in_data;
            if (w_xfer && (r_state == ST_LEN_LO)) r_len    <= w_len;
            // Address uses the pre-increment count so it lines up with wr_en.
            if (w_lo_we) begin
                r_wr_addr      <= c_base + {r_words_loaded[ADDR_W-2:0], 1'b0};
                r_words_loaded <= r_words_loaded + 16'd1;
            end
        end
    end

    byte_pair_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_start_ok),
        .hi_we   (w_hi_we),
        .lo_we   (w_lo_we),
        .byte_in (in_data),
        .wr_en   (wr_en),
        .wr_data (wr_data)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .csum    (w_csum)
`endif
    );

    assign wr_addr      = r_wr_addr;
    assign words_loaded = r_words_loaded;
    assign done         = (r_state == ST_DONE);
    assign error        = (r_state == ST_ERROR);
    assign cpu_hold     = !is_rest_state(r_state);

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: loads a program into the byte-addressed instruction store from a byte stream (e.g. a UART RX or debug port).
- Framing: 2-byte big-endian word count N, then N 16-bit instructions, each sent high byte first.
- Each instruction is written as one 16-bit word, high byte to byte address 2j and low byte to 2j+1.
- `cpu_hold` keeps the CPU stalled while a load is in progress.

Parameters:
- MEM_BYTES, 1024, capacity of the instruction store in bytes (even); maximum N = MEM_BYTES/2.
- BASE_ADDR, 0, byte address of word 0 (even).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid && in_ready at a clock edge
- start  in  1  one-cycle pulse; arms a new load (ignored unless state is IDLE, DONE or ERROR)
- wr_en  out  1  one-cycle write strobe to the instruction store
- wr_addr  out  16  byte address of the word being written, always even
- wr_data  out  16  {high byte, low byte}
- cpu_hold  out  1  high from `start` acceptance until DONE/ERROR
- done  out  1  level, load completed successfully
- error  out  1  level, load aborted
- words_loaded  out  16  count of words written in the current load

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=0, done=0, error=0, words_loaded=0, all internal registers 0.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERROR (plus CHK when the optional feature is compiled in).
- in_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- Start:
  - start in IDLE/DONE/ERROR -> LEN_HI next cycle.
  - Same edge: cpu_hold=1, done=0, error=0, words_loaded=0, wr_addr=BASE_ADDR.
  - start in any other state is ignored.
- LEN_HI: on transfer, latch len[15:8] -> LEN_LO.
- LEN_LO: on transfer, latch len[7:0]; the check uses the assembled length.
  - len==0 -> DONE.
  - len > MEM_BYTES/2 -> ERROR.
  - otherwise -> DATA_HI.
- DATA_HI: on transfer, latch hi byte -> DATA_LO.
- DATA_LO: on transfer:
  - Next cycle: wr_en=1 for exactly one cycle, wr_data={hi,in_data}, wr_addr = BASE_ADDR + 2*words_loaded (pre-increment value).
  - Same cycle: words_loaded increments.
  - If words_loaded+1 == len -> DONE (or CHK); else -> DATA_HI.
  - Write latency: 1 cycle after the low-byte transfer.
  - The store accepts every strobe; there is no write backpressure.
- wr_addr arithmetic is 16-bit modulo. With the length check in place it never exceeds BASE_ADDR+MEM_BYTES-2.
- DONE: done=1, cpu_hold=0; held until the next start.
- ERROR: error=1, cpu_hold=0; held until the next start. Words already written stay in the store (no rollback).
- in_valid low: the state holds indefinitely; there is no timeout.
- start pulse coincident with a transfer in DONE/ERROR: start wins, and the byte is not consumed (in_ready=0 there).
- Reset mid-load aborts immediately with no partial-word write. wr_en is forced low asynchronously.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes (excluding the length bytes) is cleared on start.
  - After the last word the FSM goes to CHK and accepts one byte.
  - Byte equals the XOR -> DONE; otherwise ERROR.
  - The last wr_en still occurs, 1 cycle after the final low byte.
  - len==0 also passes through CHK; the expected byte is 0x00.
- Undefined: no CHK state and no checksum register; the FSM goes from the last DATA_LO straight to DONE.

Decomposition:
- Shared package `cpu_pkg`: state enumeration for the loader FSM, constants INSTR_W=16 and BYTE_W=8, address width 16.
- Sub-module `byte_pair_assembler`: holds the hi-byte register, emits the word strobe, and keeps the XOR accumulator under the macro.
- The FSM, counters and length check stay in imem_loader.

Test Plan:
- Basic load: start, stream 00 02 12 34 AB CD with in_valid held high.
  - Expect wr_en at addr 0x0000 data 0x1234, then addr 0x0002 data 0xABCD.
  - Then done=1, cpu_hold=0, words_loaded=2.
- Backpressure gaps: same stream with in_valid toggled randomly -> identical writes; no extra or duplicate wr_en.
- Zero and oversize length:
  - 00 00 -> done, no wr_en.
  - 02 01 (513 > 512) -> error, no wr_en.
  - 02 00 followed by 512 words -> last write at addr 0x03FE, then done.
- Reset mid-load: assert rst_n=0 after the hi byte of word 1.
  - Expect all outputs at reset values immediately and no write of a partial word.
  - A new start then reloads correctly from addr 0.
- Restart / ignored start: start pulse during DATA_HI is ignored; start after error clears error and reloads.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - 00 01 12 34 26 -> done.
  - 00 01 12 34 27 -> error, with the word at addr 0 still written.
